run_length_meter: RTL and testbench
===================================

// Module: run_length_meter
// PURPOSE
//  Iterative longest-run meter. Loads a W-bit word on start, then repeatedly applies
//  v <= (v<<1) & v, counting iterations until v==0; the count is the longest run of
//  consecutive 1s (mode=0) or 0s (mode=1). This is the parametrised successor of the
//  fixed 32-bit run counter: it adds busy/done handshake, restart and zero-run mode.
// PARAMETERS
//  W   32              operand width, >=2
//  CW  $clog2(W+1)     result width (holds 0..W); derived, do not override
//  IW  $clog2(W)       bit-index width (RUN_POS_EN only); derived
// PORTS
//  clk      in   1   clock; all state updates on the FALLING edge
//  rst_n    in   1   synchronous reset, active-low, sampled on falling edge of clk
//  start    in   1   load x and begin; accepted in any state
//  mode     in   1   0: longest run of 1s; 1: longest run of 0s (sampled with start)
//  x        in   W   operand, sampled only when start=1
//  busy     out  1   1 while iterating (state RUN)
//  rdy      out  1   combinational !busy
//  done     out  1   one-cycle pulse when result becomes valid
//  len      out  CW  run length; valid from done until next start; held in IDLE
//  run_lsb  out  IW  (RUN_POS_EN only) bit index of the lowest bit of the reported run
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, v=0, len=0, done=0, busy=0, run_lsb=0.
//    Reset overrides start; reset mid-RUN aborts with no done pulse.
//  - States: IDLE, RUN. busy = (state==RUN).
//  - start=1 (any state): v <= mode ? ~x : x; len <= 0; state <= RUN; done <= 0.
//  - RUN, v!=0: v <= (v<<1) & v (zero shifted into bit 0); len <= len+1.
//  - RUN, v==0: state <= IDLE; done <= 1 for exactly one cycle.
//  - IDLE, no start: all registers hold; done <= 0.
//  - Latency: done high for the cycle after edge L+1 following the start edge (L=len);
//    x=0 -> done after 1 edge, len=0; all-ones -> len=W, W+1 edges, max latency.
//  - len increment cannot overflow: at most W increments, CW covers W.
//  - start while busy: current op silently discarded and restarted, no done for it.
//  - start on the completion edge: start wins, done stays 0.
//  - mode and x are ignored except on the start edge.
// CONFIGURATION
//  Macro RUN_LENGTH_METER_POS_EN:
//  - defined: port run_lsb present. In RUN with v!=0, pos <= index of lowest set bit of
//    v; at done run_lsb = pos - len + 1 (lowest run when several tie). len=0 -> run_lsb=0.
//  - undefined: no run_lsb port, no pos register, no priority encoder.
// STRUCTURE
//  - run_meter_pkg: typedef enum logic {IDLE, RUN} run_state_t; function clog2-based
//    width helpers; localparam MODE_ONES=1'b0, MODE_ZEROS=1'b1.
//  - Sub-module lsb_index #(W) (combinational lowest-set-bit priority encoder),
//    instantiated only under RUN_LENGTH_METER_POS_EN.
//  - Single always_ff @(negedge clk) for v/len/state/done; rdy as a continuous assign.
// TESTING (W=32 unless noted)
//  1. start, mode=0, x=32'h0000_0F0F -> done after 5 edges, len=4, run_lsb=0 (POS_EN).
//  2. x=32'h0, mode=0 -> done after 1 edge, len=0; x=32'hFFFF_FFFF -> len=32, 33 edges.
//  3. mode=1, x=32'hFF00_00FF -> longest zero run, len=16, run_lsb=8 (POS_EN).
//  4. x=32'h7F, start again 3 edges later with x=32'h3 -> one done only, len=2.
//  5. rst_n=0 for 1 edge mid-RUN (x=32'hFFFF) -> busy=0, len=0, no done; start+rst_n=0
//     same edge -> stays IDLE.
//  6. W=8 build, x=8'hFF -> len=8 (CW=4); random x vs. reference model, both modes.

Source files
------------

// File: rtl/run_meter_pkg.sv
// Shared types and width helpers for the longest-run meter.
package run_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

  // Width needed to hold a run length 0..w
  function automatic int unsigned len_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Width needed to hold a bit index 0..w-1
  function automatic int unsigned idx_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/lsb_index.sv
// Lowest-set-bit priority encoder used for run position reporting.
// Only exists when RUN_LENGTH_METER_POS_EN is defined; otherwise this file is empty.
`ifdef RUN_LENGTH_METER_POS_EN
module lsb_index
  import run_meter_pkg::*;
#(
  parameter  int unsigned W  = 32,
  localparam int unsigned IW = idx_width(W)
) (
  input  logic [W-1:0]  v,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
    end
  end

endmodule
`endif

// File: rtl/run_length_meter.sv
// Iterative longest-run meter: v <= (v<<1) & v until zero, counting iterations.
// All state updates on the falling clock edge; reset is synchronous, active-low.
// Optional feature macro: RUN_LENGTH_METER_POS_EN adds run_lsb (position of the run).
module run_length_meter
  import run_meter_pkg::*;
#(
  parameter  int unsigned W  = 32,
  localparam int unsigned CW = len_width(W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic [W-1:0]             x,
  output logic                     busy,
  output logic                     rdy,
  output logic                     done,
  output logic [CW-1:0]            len
`ifdef RUN_LENGTH_METER_POS_EN
  ,
  output logic [idx_width(W)-1:0]  run_lsb
`endif
);

  run_state_t    state, state_nxt;
  logic [W-1:0]  v, v_nxt;
  logic [CW-1:0] len_nxt;
  logic          done_nxt;

`ifdef RUN_LENGTH_METER_POS_EN
  localparam int unsigned IW = idx_width(W);
  localparam int unsigned DW = ((CW > IW) ? CW : IW) + 1;

  logic [IW-1:0] pos, pos_nxt, run_lsb_nxt, low_idx;
  logic [DW-1:0] lsb_calc;

  lsb_index #(.W(W)) u_lsb_index (
    .v   (v),
    .idx (low_idx)
  );

  // pos tracks the top of the surviving run; subtract the run length back down
  assign lsb_calc = DW'(pos) + DW'(1) - DW'(len);
`endif

  // State and datapath registers, updated on the falling edge
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      v     <= '0;
      len   <= '0;
      done  <= 1'b0;
`ifdef RUN_LENGTH_METER_POS_EN
      pos     <= '0;
      run_lsb <= '0;
`endif
    end else begin
      state <= state_nxt;
      v     <= v_nxt;
      len   <= len_nxt;
      done  <= done_nxt;
`ifdef RUN_LENGTH_METER_POS_EN
      pos     <= pos_nxt;
      run_lsb <= run_lsb_nxt;
`endif
    end
  end

  // Next-state and datapath: start always wins, otherwise iterate or finish
  always_comb begin
    state_nxt = state;
    v_nxt     = v;
    len_nxt   = len;
    done_nxt  = 1'b0;
`ifdef RUN_LENGTH_METER_POS_EN
    pos_nxt     = pos;
    run_lsb_nxt = run_lsb;
`endif
    if (start) begin
      v_nxt     = (mode == MODE_ZEROS) ? ~x : x;
      len_nxt   = '0;
      state_nxt = RUN;
    end else if (state == RUN) begin
      if (v != '0) begin
        v_nxt   = (v << 1) & v;
        len_nxt = len + CW'(1);
`ifdef RUN_LENGTH_METER_POS_EN
        pos_nxt = low_idx;
`endif
      end else begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
`ifdef RUN_LENGTH_METER_POS_EN
        run_lsb_nxt = (len == '0) ? '0 : IW'(lsb_calc);
`endif
      end
    end
  end

  // Status decode from the state register
  always_comb begin
    busy = 1'b0;
    if (state == RUN) busy = 1'b1;
  end

  assign rdy = !busy;

endmodule

// File: tb/tb_run_length_meter.sv
// Scoreboard bench for run_length_meter: a 32-bit and an 8-bit instance.
module tb_run_length_meter;
  import run_meter_pkg::*;

  localparam int unsigned CW  = 6;
  localparam int unsigned CW8 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, mode, start8, mode8;
  logic [31:0]    x;
  logic [7:0]     x8;
  logic           busy, rdy, done, busy8, rdy8, done8;
  logic [CW-1:0]  len;
  logic [CW8-1:0] len8;
`ifdef RUN_LENGTH_METER_POS_EN
  logic [4:0]     run_lsb;
  logic [2:0]     run_lsb8;
`endif

  typedef struct {
    int unsigned len;
    int unsigned lsb;
    int unsigned cyc;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned n_done32 = 0, n_done8 = 0, exp_done32 = 0, exp_done8 = 0;

  run_length_meter #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .x     (x),
    .busy  (busy),
    .rdy   (rdy),
    .done  (done),
    .len   (len)
`ifdef RUN_LENGTH_METER_POS_EN
    ,
    .run_lsb (run_lsb)
`endif
  );

  run_length_meter #(.W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .mode  (mode8),
    .x     (x8),
    .busy  (busy8),
    .rdy   (rdy8),
    .done  (done8),
    .len   (len8)
`ifdef RUN_LENGTH_METER_POS_EN
    ,
    .run_lsb (run_lsb8)
`endif
  );

  // Falling-edge counter used to measure latency from the start edge
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Reference: scan bits, longest run of the selected polarity, lowest on ties
  function automatic exp_t model(input logic [31:0] val, input int unsigned w, input logic m);
    exp_t        e;
    int unsigned cur;
    cur   = 0;
    e.len = 0;
    e.lsb = 0;
    e.cyc = 0;
    for (int unsigned i = 0; i < w; i++) begin
      if (val[i] != m) begin
        cur++;
        if (cur > e.len) begin
          e.len = cur;
          e.lsb = i + 1 - cur;
        end
      end else begin
        cur = 0;
      end
    end
    return e;
  endfunction

  // 32-bit result monitor
  always @(posedge clk) begin
    if (done) begin
      n_done32++;
      if (q32.size() == 0) begin
        check("done32_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("len32", 32'(len), e.len);
        check("lat32", cyc - e.cyc, e.len + 1);
        check("busy32_at_done", 32'(busy), 0);
        check("rdy32_at_done", 32'(rdy), 1);
`ifdef RUN_LENGTH_METER_POS_EN
        check("lsb32", 32'(run_lsb), e.lsb);
`endif
      end
    end
  end

  // 8-bit result monitor
  always @(posedge clk) begin
    if (done8) begin
      n_done8++;
      if (q8.size() == 0) begin
        check("done8_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("len8", 32'(len8), e.len);
        check("lat8", cyc - e.cyc, e.len + 1);
`ifdef RUN_LENGTH_METER_POS_EN
        check("lsb8", 32'(run_lsb8), e.lsb);
`endif
      end
    end
  end

  // Issue one start pulse; a still-pending op is superseded by the restart
  task automatic run_op(input bit narrow, input logic m, input logic [31:0] val);
    exp_t e;
    @(posedge clk); #1;
    e     = model(val, narrow ? 8 : 32, m);
    e.cyc = cyc + 1;
    if (narrow) begin
      if (q8.size() != 0) begin q8.delete(0); exp_done8--; end
      q8.push_back(e); exp_done8++;
      start8 = 1'b1; mode8 = m; x8 = val[7:0];
    end else begin
      if (q32.size() != 0) begin q32.delete(0); exp_done32--; end
      q32.push_back(e); exp_done32++;
      start = 1'b1; mode = m; x = val;
    end
    @(posedge clk); #1;
    if (narrow) begin
      start8 = 1'b0; mode8 = ~m; x8 = 8'($urandom());
    end else begin
      start = 1'b0; mode = ~m; x = $urandom();
    end
  endtask

  task automatic wait_idle(input bit narrow, input int budget);
    int i;
    i = 0;
    while ((narrow ? q8.size() : q32.size()) != 0 && i < budget) begin
      @(posedge clk); #2;
      i++;
    end
    if (narrow && q8.size() != 0) begin
      check("timeout8", q8.size(), 0);
      exp_done8 -= q8.size();
      q8.delete();
    end
    if (!narrow && q32.size() != 0) begin
      check("timeout32", q32.size(), 0);
      exp_done32 -= q32.size();
      q32.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    logic m;
    rst_n = 1'b0; start = 1'b0; mode = MODE_ONES; x = '0;
    start8 = 1'b0; mode8 = MODE_ONES; x8 = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_rdy", 32'(rdy), 1);
    check("rst_done", 32'(done), 0);
    check("rst_len", 32'(len), 0);
    check("rst_len8", 32'(len8), 0);
`ifdef RUN_LENGTH_METER_POS_EN
    check("rst_lsb", 32'(run_lsb), 0);
`endif
    rst_n = 1'b1;

    // Basic run of ones, then result held while idle
    run_op(0, MODE_ONES, 32'h0000_0F0F);
    wait_idle(0, 60);
    repeat (3) @(posedge clk); #2;
    check("len_hold", 32'(len), 4);
    check("done_low_idle", 32'(done), 0);
    check("rdy_idle", 32'(rdy), 1);

    // Extremes: zero operand and all ones
    run_op(0, MODE_ONES, 32'h0);
    wait_idle(0, 60);
    run_op(0, MODE_ONES, 32'hFFFF_FFFF);
    wait_idle(0, 60);
    run_op(0, MODE_ZEROS, 32'h0);
    wait_idle(0, 60);

    // Zero-run mode
    run_op(0, MODE_ZEROS, 32'hFF00_00FF);
    wait_idle(0, 60);

    // Restart while busy: only the second op reports
    run_op(0, MODE_ONES, 32'h0000_007F);
    repeat (2) @(posedge clk);
    run_op(0, MODE_ONES, 32'h0000_0003);
    wait_idle(0, 60);

    // Start on the completion edge of the previous op
    run_op(0, MODE_ONES, 32'h0000_0003);
    @(posedge clk);
    run_op(0, MODE_ONES, 32'h0000_001F);
    wait_idle(0, 60);

    // Reset mid-run aborts with no done
    run_op(0, MODE_ONES, 32'h0000_FFFF);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    exp_done32 -= q32.size();
    q32.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 0);
    check("abort_len", 32'(len), 0);
    check("abort_done", 32'(done), 0);

    // Reset beats start on the same edge
    rst_n = 1'b0; start = 1'b1; x = 32'hFF;
    @(posedge clk); #1;
    check("rst_start_busy", 32'(busy), 0);
    check("rst_start_len", 32'(len), 0);
    start = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk); #2;
    check("rst_start_idle", 32'(busy), 0);
    check("rst_start_nodone", 32'(done), 0);

    // Narrow instance boundaries
    run_op(1, MODE_ONES, 32'hFF);
    wait_idle(1, 30);
    run_op(1, MODE_ZEROS, 32'h00);
    wait_idle(1, 30);
    run_op(1, MODE_ONES, 32'h00);
    wait_idle(1, 30);

    // Random operands, both modes, both widths
    for (int i = 0; i < 16; i++) begin
      m = 1'($urandom_range(0, 1));
      run_op(0, m, $urandom());
      wait_idle(0, 60);
      run_op(1, m, $urandom());
      wait_idle(1, 30);
    end

    repeat (4) @(posedge clk); #2;
    check("done32_count", n_done32, exp_done32);
    check("done8_count", n_done8, exp_done8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
